// File: rtl/fperm_issue_arb_pkg.sv
// Shared definitions for the fperm issue path: op-field layout, operand
// width, issue-register record and the table-hold FSM states.
package fperm_issue_arb_pkg;

  localparam int FPOP_W = 10;
  localparam int FP_DW  = 68;

  // Bit positions inside the 10-bit op word
  // {copyA,swpSngl,dupSngl,is_sqrt,is_div,tbl_read,tbl_write,xtra[2:0]}
  localparam int FPOP_COPYA     = 9;
  localparam int FPOP_SWPSNGL   = 8;
  localparam int FPOP_DUPSNGL   = 7;
  localparam int FPOP_IS_SQRT   = 6;
  localparam int FPOP_IS_DIV    = 5;
  localparam int FPOP_TBL_READ  = 4;
  localparam int FPOP_TBL_WRITE = 3;
  localparam int FPOP_XTRA      = 0;
  localparam int FPOP_XTRA_W    = 3;

  typedef enum logic [0:0] {
    FP_RUN     = 1'b0,
    FP_TBLHOLD = 1'b1
  } fp_state_e;

  // Fields latched into the issue register and driven to the unit
  typedef struct packed {
    logic [FPOP_W-1:0] op;
    logic [FP_DW-1:0]  a;
    logic [FP_DW-1:0]  b;
  } fp_iss_t;

  // A read+write op is illegal and handled as a write, so it is not a read
  function automatic logic op_tbl_read(input logic [FPOP_W-1:0] op);
    return op[FPOP_TBL_READ] & ~op[FPOP_TBL_WRITE];
  endfunction

  function automatic logic op_tbl_write(input logic [FPOP_W-1:0] op);
    return op[FPOP_TBL_WRITE];
  endfunction

endpackage

// File: rtl/fperm_issue_arb_if.sv
// Requester, unit and result signals of the fperm issue arbiter.
// master = issue-queue/unit side, slave = the arbiter.
interface fperm_issue_arb_if #(
  parameter int NREQ = 4,
  parameter int TAGW = 6
);
  import fperm_issue_arb_pkg::*;

  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0]             req_vld;
  logic [NREQ-1:0][FPOP_W-1:0] req_op;
  logic [NREQ-1:0][FP_DW-1:0]  req_A;
  logic [NREQ-1:0][FP_DW-1:0]  req_B;
  logic [NREQ-1:0][TAGW-1:0]   req_tag;
  logic [NREQ-1:0]             req_gnt;
  logic                        flush;

  logic                        u_en;
  logic [FPOP_W-1:0]           u_op;
  logic [FP_DW-1:0]            u_A;
  logic [FP_DW-1:0]            u_B;

  logic                        res_vld;
  logic [TAGW-1:0]             res_tag;
  logic [SW-1:0]               res_src;
  logic                        busy;

  modport master (
    output req_vld, req_op, req_A, req_B, req_tag, flush,
    input  req_gnt, u_en, u_op, u_A, u_B, res_vld, res_tag, res_src, busy
  );

  modport slave (
    input  req_vld, req_op, req_A, req_B, req_tag, flush,
    output req_gnt, u_en, u_op, u_A, u_B, res_vld, res_tag, res_src, busy
  );

endinterface

// File: rtl/fperm_issue_arb_rr_arb.sv
// Rotating-priority one-hot picker. Search starts at the pointer and wraps
// at N-1 -> 0; the pointer moves just past the winner on every grant.
module rr_arb #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_any,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  int            idx;

  // First requester at or after the pointer, wrapping
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = PW'(idx);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = gnt_any;
  end

  // Pointer update; explicit wrap keeps non-power-of-2 N in range
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (gnt_any)
      ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/fperm_issue_arb.sv
// Shares one fperm unit between NREQ issue queues: round-robin grant,
// issue register to the unit, fixed-latency tag pipe for result tagging,
// table write->read gap FSM and in-flight flush.
module fperm_issue_arb
  import fperm_issue_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int LAT    = 1,
  parameter int TBLGAP = 2,
  parameter int TAGW   = 6
) (
  input logic              clk,
  input logic              rst,
  fperm_issue_arb_if.slave bus
);

  localparam int SW = $clog2(NREQ);
  localparam int GW = $clog2(TBLGAP + 1);

  fp_state_e                 state;
  logic [GW-1:0]             gap_cnt;
  logic                      hold;
  logic [NREQ-1:0]           elig;
  logic [NREQ-1:0]           gnt;
  logic                      gnt_any;
  logic [SW-1:0]             gidx;
  logic [FPOP_W-1:0]         gop;
  fp_iss_t                   iss_q;
  // stage 0 is the issue register (u_en), stage LAT is the result cycle
  logic [LAT:0]              vld_pipe;
  logic [LAT:0][TAGW-1:0]    tag_pipe;
  logic [LAT:0][SW-1:0]      src_pipe;

  assign hold = (state == FP_TBLHOLD);
  assign gop  = bus.req_op[gidx];

  // Table reads wait out the hold window; flush and reset suppress grants
  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign elig[i] = bus.req_vld[i] & ~(op_tbl_read(bus.req_op[i]) & hold)
                   & ~bus.flush & ~rst;
  end

  rr_arb #(.N(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (elig),
    .gnt     (gnt),
    .gnt_any (gnt_any),
    .gnt_idx (gidx)
  );

  // Issue register: capture the winner's fields, hold them when idle
  always_ff @(posedge clk) begin
    if (rst)
      iss_q <= '0;
    else if (gnt_any)
      iss_q <= '{op: gop, a: bus.req_A[gidx], b: bus.req_B[gidx]};
  end

  // Valid/tag/source pipe tracking the unit's fixed latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      src_pipe <= '0;
    end else begin
      vld_pipe <= bus.flush ? '0 : {vld_pipe[LAT-1:0], gnt_any};
      if (gnt_any) begin
        tag_pipe[0] <= bus.req_tag[gidx];
        src_pipe[0] <= gidx;
      end
      for (int k = 1; k <= LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
        src_pipe[k] <= src_pipe[k-1];
      end
    end
  end

  // Table hold FSM; flush leaves it alone since the table is already written
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FP_RUN;
      gap_cnt <= '0;
    end else begin
      case (state)
        FP_RUN: begin
          if (gnt_any && op_tbl_write(gop)) begin
            state   <= FP_TBLHOLD;
            gap_cnt <= GW'(TBLGAP);
          end
        end
        FP_TBLHOLD: begin
          if (gnt_any && op_tbl_write(gop))
            gap_cnt <= GW'(TBLGAP);
          else if (gap_cnt <= GW'(1)) begin
            state   <= FP_RUN;
            gap_cnt <= '0;
          end else
            gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          state   <= FP_RUN;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  a_tbl_rw_excl: assert property (@(posedge clk) disable iff (rst)
    gnt_any |-> !(gop[FPOP_TBL_READ] && gop[FPOP_TBL_WRITE]));

  assign bus.req_gnt = gnt;
  assign bus.u_en    = vld_pipe[0];
  assign bus.u_op    = iss_q.op;
  assign bus.u_A     = iss_q.a;
  assign bus.u_B     = iss_q.b;
  assign bus.res_vld = vld_pipe[LAT];
  assign bus.res_tag = tag_pipe[LAT];
  assign bus.res_src = src_pipe[LAT];
  assign bus.busy    = (|vld_pipe) | hold;

endmodule
